// File: rtl/alarm_ring_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl_pkg
//   Shared definitions for the ring-tone path: the alarm session state
//   encoding and the default period constants used by both the ring clock
//   divider and the ring controller.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package alarm_ring_ctrl_pkg;

    // Alarm session state. The encoding is fixed because other blocks
    // (and anyone probing the state bus) rely on these values.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_t;

    // Defaults in units of ring_clk rising edges.
    localparam int DEF_RING_PERIODS   = 60;
    localparam int DEF_SNOOZE_PERIODS = 300;
    localparam int DEF_MAX_SNOOZE     = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width needed to count 0..n-1; a one-period limit still needs one bit.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : alarm_ring_ctrl_pkg

// File: rtl/alarm_ring_ctrl_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous square wave into the clk domain through a two
//   flop synchroniser and produces a one-clk rising-edge pulse.
//   Ports:
//     clk       in  system clock
//     reset_n   in  asynchronous active-low reset (clears all flops)
//     async_in  in  asynchronous input
//     level     out synchronised level (two flops after async_in)
//     rise      out one-cycle pulse when level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic stage1;
    logic stage2;
    logic stage2_q;

    // stage1 may go metastable; only stage2 onwards is used by logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1   <= 1'b0;
            stage2   <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1   <= async_in;
            stage2   <= stage1;
            stage2_q <= stage2;
        end
    end

    assign level = stage2;
    assign rise  = stage2 & ~stage2_q;

endmodule : sync_edge_det

// File: rtl/alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl
//   Owns the alarm session (start on alarm match, stop, snooze, timeout) and
//   gates the synchronised ring-tone square wave onto the buzzer/LED.
//   Ports:
//     clk          in  system clock, all logic on posedge
//     reset_n      in  asynchronous active-low reset
//     ring_clk_in  in  ring-tone square wave from divider (asynchronous)
//     alarm_match  in  alarm comparator level (clk-synchronous)
//     stop_btn     in  debounced stop button level
//     snooze_btn   in  debounced snooze button level
//     ring_out     out buzzer/LED drive, registered
//     ringing      out high while in RING, registered
//     snoozed      out high while in SNOOZE, registered
//     snooze_cnt   out snoozes used in the current session
// ---------------------------------------------------------------------------
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int RING_PERIODS   = DEF_RING_PERIODS,
    parameter int SNOOZE_PERIODS = DEF_SNOOZE_PERIODS,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ring_clk_in,
    input  logic       alarm_match,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       ring_out,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] snooze_cnt
);

    localparam int CNT_W = count_width(max_int(RING_PERIODS, SNOOZE_PERIODS));
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_PERIODS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_PERIODS - 1);
    localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    ring_state_t      state;
    ring_state_t      next_state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] next_counter;
    logic [1:0]       next_snooze_cnt;

    logic ring_level;
    logic tick;

    logic match_q;
    logic stop_q;
    logic snooze_q;
    logic match_rise;
    logic stop_rise;
    logic snooze_rise;

    sync_edge_det u_ring_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (ring_clk_in),
        .level    (ring_level),
        .rise     (tick)
    );

    // The history flops reset high so that a level already asserted when
    // reset is released is not mistaken for a fresh press or match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q  <= 1'b1;
            stop_q   <= 1'b1;
            snooze_q <= 1'b1;
        end else begin
            match_q  <= alarm_match;
            stop_q   <= stop_btn;
            snooze_q <= snooze_btn;
        end
    end

    assign match_rise  = alarm_match & ~match_q;
    assign stop_rise   = stop_btn    & ~stop_q;
    assign snooze_rise = snooze_btn  & ~snooze_q;

    // Session state, period counter and the registered outputs. The outputs
    // are built from next_state so they change on the same edge as the
    // state and ring_out never outlives the RING state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            counter    <= '0;
            snooze_cnt <= 2'd0;
            ring_out   <= 1'b0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            state      <= next_state;
            counter    <= next_counter;
            snooze_cnt <= next_snooze_cnt;
            ring_out   <= ring_level & (next_state == RING);
            ringing    <= (next_state == RING);
            snoozed    <= (next_state == SNOOZE);
        end
    end

    // Next-state logic. Stop always wins; in RING an honoured snooze beats a
    // coincident timeout tick. A snooze beyond the limit falls through to the
    // normal tick handling so the ring carries on with its counter intact.
    always_comb begin
        next_state      = state;
        next_counter    = counter;
        next_snooze_cnt = snooze_cnt;
        case (state)
            IDLE: begin
                if (match_rise) begin
                    next_state      = RING;
                    next_counter    = '0;
                    next_snooze_cnt = 2'd0;
                end
            end
            RING: begin
                if (stop_rise) begin
                    next_state = IDLE;
                end else if (snooze_rise && (snooze_cnt < SNOOZE_LIMIT)) begin
                    next_state      = SNOOZE;
                    next_counter    = '0;
                    next_snooze_cnt = snooze_cnt + 2'd1;
                end else if (tick) begin
                    if (counter == RING_LAST) begin
                        next_state = IDLE;
                    end else begin
                        next_counter = counter + 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (stop_rise) begin
                    next_state = IDLE;
                end else if (tick) begin
                    if (counter == SNOOZE_LAST) begin
                        next_state   = RING;
                        next_counter = '0;
                    end else begin
                        next_counter = counter + 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule : alarm_ring_ctrl
